// File: rtl/fp_accum_seq_if.sv
// Handshake bundle between the accumulation sequencer (master) and the
// single-precision FP adder (slave).
interface fp_accum_seq_if;
  logic        add_start;
  logic [31:0] add_a;
  logic        add_a_stb;
  logic        add_a_ack;
  logic [31:0] add_b;
  logic        add_b_stb;
  logic        add_b_ack;
  logic [31:0] add_z;
  logic        add_z_stb;
  logic        add_z_ack;
  logic        add_idle;
  logic        add_output_valid;

  modport master (
    output add_start,
    output add_a, add_a_stb,
    input  add_a_ack,
    output add_b, add_b_stb,
    input  add_b_ack,
    input  add_z, add_z_stb,
    output add_z_ack,
    input  add_idle, add_output_valid
  );

  modport slave (
    input  add_start,
    input  add_a, add_a_stb,
    output add_a_ack,
    input  add_b, add_b_stb,
    output add_b_ack,
    output add_z, add_z_stb,
    input  add_z_ack,
    output add_idle, add_output_valid
  );
endinterface

// File: rtl/fp_accum_seq.sv
// Sums binary32 vectors element by element through an external FP adder,
// emitting one sum and element count per vector, with a per-state watchdog.
module fp_accum_seq #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      sum_data,
  output logic [CNT_W-1:0] sum_count,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             err,
  fp_accum_seq_if.master   add
);

  localparam int          WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IN, S_START, S_A, S_B, S_Z, S_DONE, S_OUT, S_DRAIN
  } state_t;

  state_t            state, state_next;
  logic [31:0]       acc;
  logic [31:0]       x;
  logic              last;
  logic [CNT_W-1:0]  count;
  logic [WD_W-1:0]   wd;
  logic              waiting;
  logic              progress;
  logic              timeout;

  // A completing handshake always wins over an expiring watchdog.
  always_comb begin
    waiting  = state inside {S_START, S_A, S_B, S_Z, S_DONE};
    progress = 1'b0;
    case (state)
      S_START: progress = add.add_idle;
      S_A:     progress = add.add_a_ack;
      S_B:     progress = add.add_b_ack;
      S_Z:     progress = add.add_z_stb;
      S_DONE:  progress = add.add_output_valid;
      default: progress = 1'b0;
    endcase
    timeout = waiting && !progress && (wd == WD_W'(TIMEOUT - 1));
  end

  always_comb begin
    state_next           = state;
    in_ready             = 1'b0;
    sum_valid            = 1'b0;
    sum_data             = 32'd0;
    sum_count            = '0;
    add.add_start        = 1'b0;
    add.add_a            = 32'd0;
    add.add_a_stb        = 1'b0;
    add.add_b            = 32'd0;
    add.add_b_stb        = 1'b0;
    add.add_z_ack        = 1'b0;
    case (state)
      S_IN: begin
        in_ready = !rst;
        if (in_valid) state_next = S_START;
      end
      S_START: begin
        if (add.add_idle) begin
          add.add_start = 1'b1;
          state_next    = S_A;
        end
      end
      S_A: begin
        add.add_a     = acc;
        add.add_a_stb = 1'b1;
        if (add.add_a_ack) state_next = S_B;
      end
      S_B: begin
        add.add_b     = x;
        add.add_b_stb = 1'b1;
        if (add.add_b_ack) state_next = S_Z;
      end
      S_Z: begin
        add.add_z_ack = 1'b1;
        if (add.add_z_stb) state_next = S_DONE;
      end
      S_DONE: begin
        add.add_z_ack = 1'b1;
        if (add.add_output_valid) state_next = last ? S_OUT : S_IN;
      end
      S_OUT: begin
        sum_valid = 1'b1;
        sum_data  = acc;
        sum_count = count;
        if (sum_ready) state_next = S_IN;
      end
      S_DRAIN: begin
        in_ready = !rst;
        if (in_valid && in_last) state_next = S_OUT;
      end
      default: state_next = S_IN;
    endcase
    if (timeout) state_next = last ? S_OUT : S_DRAIN;
  end

  // Watchdog restarts on every state change so each adder wait gets its own budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IN;
      acc   <= 32'd0;
      x     <= 32'd0;
      last  <= 1'b0;
      count <= '0;
      wd    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      wd    <= (!waiting || state_next != state) ? '0 : wd + WD_W'(1);
      if (state == S_IN && in_valid) begin
        x    <= in_data;
        last <= in_last;
      end
      if (timeout) begin
        err <= 1'b1;
        acc <= QNAN;
      end else if (state == S_Z && add.add_z_stb) begin
        acc <= add.add_z;
        if (count != '1) count <= count + CNT_W'(1);
      end
      if (state == S_OUT && sum_ready) begin
        acc   <= 32'd0;
        count <= '0;
      end
    end
  end

endmodule
